// File: rtl/branch_pkg.sv
// Shared definitions for jump resolution: condition codes, flag bit positions, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_pkg;

   // Condition codes as encoded by the instruction decoder
   localparam logic [2:0] COND_JMP = 3'd0;
   localparam logic [2:0] COND_JEQ = 3'd1;
   localparam logic [2:0] COND_JNE = 3'd2;
   localparam logic [2:0] COND_JGT = 3'd3;
   localparam logic [2:0] COND_JGE = 3'd4;
   localparam logic [2:0] COND_JLT = 3'd5;
   localparam logic [2:0] COND_JLE = 3'd6;
   localparam logic [2:0] COND_JCR = 3'd7;

   // Bit positions inside the latched ZNCV flag word
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Resolver FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_EVAL = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/branch_cond_eval.sv
// Decides whether a conditional jump is taken from a condition code and ZNCV flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, usable by decoder lookahead as well.
module branch_cond_eval
   import branch_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [3:0] flags,
   output logic       taken
);

   logic z, n, c, v;

   assign z = flags[FLAG_Z];
   assign n = flags[FLAG_N];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // Signed comparisons use N==V as "greater or equal" after a subtract
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_JMP: taken = 1'b1;
         COND_JEQ: taken = z;
         COND_JNE: taken = !z;
         COND_JGT: taken = !z && (n == v);
         COND_JGE: taken = (n == v);
         COND_JLT: taken = (n != v);
         COND_JLE: taken = z || (n != v);
         COND_JCR: taken = c;
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// Resolves conditional jumps on latched ZNCV flags and issues a one-cycle PC-load command.
// Latency: done_o in the cycle after accept edge +2, plus one cycle per flag-pending HOLD cycle.
// Backpressure: ready_o only in IDLE; a request is held until resolved, errored out or flushed.
module branch_resolver
   import branch_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int HOLD_MAX = 4,
   parameter int CNT_W    = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [2:0]        cond_i,
   input  logic [ADDR_W-1:0] target_i,
   input  logic [3:0]        flags_i,
   input  logic              flags_pending_i,
   input  logic              flush_i,
   output logic              done_o,
   output logic              pc_load_o,
   output logic [ADDR_W-1:0] pc_target_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  taken_cnt_o,
   output logic [CNT_W-1:0]  eval_cnt_o
);

   // Hold counter only needs to reach HOLD_MAX-1
   localparam int              HC_W      = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [1:0]        state_q;
   logic [2:0]        cond_q;
   logic [ADDR_W-1:0] target_q;
   logic [HC_W-1:0]   hold_cnt_q;
   logic              taken_q;
   logic              err_pend_q;
   logic              taken;
   logic              resp_fire;

   logic              done_q;
   logic              pc_load_q;
   logic              err_q;
   logic [ADDR_W-1:0] pc_target_q;
   logic [CNT_W-1:0]  taken_cnt_q;
   logic [CNT_W-1:0]  eval_cnt_q;

   branch_cond_eval u_cond_eval (
      .cond  (cond_q),
      .flags (flags_i),
      .taken (taken)
   );

   assign ready_o   = (state_q == ST_IDLE);
   // A flush arriving in RESP suppresses the response and its statistics
   assign resp_fire = (state_q == ST_RESP) && !flush_i;

   // Request FSM: capture, wait out flag updates, evaluate, respond
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         cond_q     <= 3'd0;
         target_q   <= '0;
         hold_cnt_q <= '0;
         taken_q    <= 1'b0;
         err_pend_q <= 1'b0;
      end else if (flush_i) begin
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid_i) begin
                  cond_q     <= cond_i;
                  target_q   <= target_i;
                  hold_cnt_q <= '0;
                  state_q    <= flags_pending_i ? ST_HOLD : ST_EVAL;
               end
            end
            ST_HOLD: begin
               if (!flags_pending_i) begin
                  state_q <= ST_EVAL;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  taken_q    <= 1'b0;
                  err_pend_q <= 1'b1;
                  state_q    <= ST_RESP;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            ST_EVAL: begin
               taken_q    <= taken;
               err_pend_q <= 1'b0;
               state_q    <= ST_RESP;
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Registered one-cycle response pulses; target is zero unless a jump is taken
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_q      <= 1'b0;
         pc_load_q   <= 1'b0;
         err_q       <= 1'b0;
         pc_target_q <= '0;
      end else begin
         done_q      <= resp_fire;
         pc_load_q   <= resp_fire && taken_q;
         err_q       <= resp_fire && err_pend_q;
         pc_target_q <= (resp_fire && taken_q) ? target_q : '0;
      end
   end

   // Saturating statistics, stepped together with the response pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         taken_cnt_q <= '0;
         eval_cnt_q  <= '0;
      end else if (resp_fire) begin
         if (eval_cnt_q != CNT_MAX) begin
            eval_cnt_q <= eval_cnt_q + 1'b1;
         end
         if (taken_q && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_q <= taken_cnt_q + 1'b1;
         end
      end
   end

   assign done_o      = done_q;
   assign pc_load_o   = pc_load_q;
   assign err_o       = err_q;
   assign pc_target_o = pc_target_q;
   assign taken_cnt_o = taken_cnt_q;
   assign eval_cnt_o  = eval_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: condition table, flag interlock, timeout error, flush, saturation, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_resolver;
   import branch_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       valid_i = 1'b0;
   logic [2:0] cond_i = 3'd0;
   logic [7:0] target_i = 8'd0;
   logic [3:0] flags_i = 4'd0;
   logic       flags_pending_i = 1'b0;
   logic       flush_i = 1'b0;

   logic        ready_o, done_o, pc_load_o, err_o;
   logic [7:0]  pc_target_o;
   logic [15:0] taken_cnt_o, eval_cnt_o;

   logic        s_ready_o, s_done_o, s_pc_load_o, s_err_o;
   logic [7:0]  s_pc_target_o;
   logic [3:0]  s_taken_cnt_o, s_eval_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_eval  = 0;
   int exp_taken = 0;

   always #5 clk_i = ~clk_i;

   branch_resolver #(.ADDR_W(8), .HOLD_MAX(4), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
      .cond_i(cond_i), .target_i(target_i), .flags_i(flags_i),
      .flags_pending_i(flags_pending_i), .flush_i(flush_i),
      .done_o(done_o), .pc_load_o(pc_load_o), .pc_target_o(pc_target_o), .err_o(err_o),
      .taken_cnt_o(taken_cnt_o), .eval_cnt_o(eval_cnt_o)
   );

   // Narrow-counter copy driven by the same stimulus, used for saturation
   branch_resolver #(.ADDR_W(8), .HOLD_MAX(4), .CNT_W(4)) dut_sat (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(s_ready_o),
      .cond_i(cond_i), .target_i(target_i), .flags_i(flags_i),
      .flags_pending_i(flags_pending_i), .flush_i(flush_i),
      .done_o(s_done_o), .pc_load_o(s_pc_load_o), .pc_target_o(s_pc_target_o), .err_o(s_err_o),
      .taken_cnt_o(s_taken_cnt_o), .eval_cnt_o(s_eval_cnt_o)
   );

   typedef struct {
      logic [2:0] cond;
      logic [3:0] flags;
      logic [7:0] target;
      logic       exp_taken;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int sat15(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic check_counters(input string tag);
      check({tag, " taken_cnt"}, 32'(taken_cnt_o), 32'(exp_taken));
      check({tag, " eval_cnt"},  32'(eval_cnt_o),  32'(exp_eval));
      check({tag, " sat taken_cnt"}, 32'(s_taken_cnt_o), 32'(sat15(exp_taken)));
      check({tag, " sat eval_cnt"},  32'(s_eval_cnt_o),  32'(sat15(exp_eval)));
   endtask

   // Waits up to 12 negedges for done_o; lat counts negedges from the call (-1 if none)
   task automatic wait_done(output int lat, output logic ld, output logic [7:0] tg,
                            output logic er, output logic done_after, output logic rdy_after);
      logic got;
      got = 1'b0;
      lat = -1; ld = 1'b0; tg = 8'd0; er = 1'b0; done_after = 1'b0; rdy_after = 1'b0;
      for (int i = 1; i <= 12 && !got; i++) begin
         @(negedge clk_i);
         if (done_o) begin
            got = 1'b1;
            lat = i; ld = pc_load_o; tg = pc_target_o; er = err_o;
         end
      end
      if (got) begin
         @(negedge clk_i);
         done_after = done_o;
         rdy_after  = ready_o;
      end
   endtask

   // Presents a request for one cycle; returns on the negedge after the accept edge
   task automatic present(input logic [2:0] c, input logic [7:0] t, input logic [3:0] f,
                          input logic pend);
      valid_i = 1'b1; cond_i = c; target_i = t; flags_i = f; flags_pending_i = pend;
      @(negedge clk_i);
      valid_i = 1'b0;
   endtask

   task automatic watch_no_done(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk_i);
         if (done_o || pc_load_o || err_o) seen = 1'b1;
      end
      check(name, 32'(seen), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      logic ld, er, da, ra;
      logic [7:0] tg;

      vecs[0]  = '{COND_JEQ, 4'b1000, 8'h2A, 1'b1};
      vecs[1]  = '{COND_JGT, 4'b0100, 8'h11, 1'b0};
      vecs[2]  = '{COND_JLT, 4'b0100, 8'h12, 1'b1};
      vecs[3]  = '{COND_JMP, 4'b0000, 8'h33, 1'b1};
      vecs[4]  = '{COND_JEQ, 4'b0000, 8'h44, 1'b0};
      vecs[5]  = '{COND_JNE, 4'b1000, 8'h55, 1'b0};
      vecs[6]  = '{COND_JNE, 4'b0000, 8'h56, 1'b1};
      vecs[7]  = '{COND_JGT, 4'b0000, 8'h57, 1'b1};
      vecs[8]  = '{COND_JGT, 4'b1000, 8'h58, 1'b0};
      vecs[9]  = '{COND_JGE, 4'b0101, 8'h59, 1'b1};
      vecs[10] = '{COND_JGE, 4'b0001, 8'h5A, 1'b0};
      vecs[11] = '{COND_JLT, 4'b0101, 8'h5B, 1'b0};
      vecs[12] = '{COND_JLE, 4'b1000, 8'h5C, 1'b1};
      vecs[13] = '{COND_JLE, 4'b0001, 8'h5D, 1'b1};
      vecs[14] = '{COND_JLE, 4'b0000, 8'h5E, 1'b0};
      vecs[15] = '{COND_JCR, 4'b0010, 8'h5F, 1'b1};
      vecs[16] = '{COND_JCR, 4'b1101, 8'h60, 1'b0};
      vecs[17] = '{COND_JMP, 4'b1111, 8'hFF, 1'b1};

      // Reset state
      #2;
      check("reset ready_o", 32'(ready_o), 32'd1);
      check("reset done_o", 32'(done_o), 32'd0);
      check("reset pc_load_o", 32'(pc_load_o), 32'd0);
      check("reset pc_target_o", 32'(pc_target_o), 32'd0);
      check("reset err_o", 32'(err_o), 32'd0);
      check_counters("reset");
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Condition table, no pending flag updates
      foreach (vecs[i]) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         check({nm, " ready before"}, 32'(ready_o), 32'd1);
         present(vecs[i].cond, vecs[i].target, vecs[i].flags, 1'b0);
         check({nm, " ready busy"}, 32'(ready_o), 32'd0);
         wait_done(lat, ld, tg, er, da, ra);
         if (vecs[i].exp_taken) exp_taken++;
         exp_eval++;
         check({nm, " latency"}, 32'(lat), 32'd2);
         check({nm, " pc_load"}, 32'(ld), 32'(vecs[i].exp_taken));
         check({nm, " pc_target"}, 32'(tg), vecs[i].exp_taken ? 32'(vecs[i].target) : 32'd0);
         check({nm, " err"}, 32'(er), 32'd0);
         check({nm, " done one cycle"}, 32'(da), 32'd0);
         check({nm, " ready after"}, 32'(ra), 32'd1);
         check_counters(nm);
      end

      // JNE with pending for accept cycle + one HOLD cycle; flags flip to 0000 at that edge
      present(COND_JNE, 8'h77, 4'b1000, 1'b1);
      check("jne hold ready", 32'(ready_o), 32'd0);
      @(negedge clk_i);
      flags_pending_i = 1'b0;
      flags_i = 4'b0000;
      wait_done(lat, ld, tg, er, da, ra);
      exp_eval++; exp_taken++;
      // two HOLD cycles: done four edges after accept, three negedges from here
      check("jne hold latency", 32'(lat), 32'd3);
      check("jne hold pc_load", 32'(ld), 32'd1);
      check("jne hold pc_target", 32'(tg), 32'h77);
      check("jne hold err", 32'(er), 32'd0);
      check_counters("jne hold");

      // Pending never clears: error after HOLD_MAX HOLD cycles
      present(COND_JMP, 8'h99, 4'b0000, 1'b1);
      wait_done(lat, ld, tg, er, da, ra);
      flags_pending_i = 1'b0;
      exp_eval++;
      check("timeout latency", 32'(lat), 32'd5);
      check("timeout err", 32'(er), 32'd1);
      check("timeout pc_load", 32'(ld), 32'd0);
      check("timeout pc_target", 32'(tg), 32'd0);
      check("timeout done one cycle", 32'(da), 32'd0);
      check_counters("timeout");

      // Flush while in EVAL
      present(COND_JMP, 8'h10, 4'b0000, 1'b0);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      check("flush eval ready", 32'(ready_o), 32'd1);
      watch_no_done("flush eval no done", 5);
      check_counters("flush eval");

      // Flush together with valid in IDLE: request not captured
      flush_i = 1'b1;
      present(COND_JMP, 8'h20, 4'b0000, 1'b0);
      flush_i = 1'b0;
      check("flush idle ready", 32'(ready_o), 32'd1);
      watch_no_done("flush idle no done", 5);
      check_counters("flush idle");

      // Asynchronous reset while in HOLD
      present(COND_JMP, 8'h30, 4'b0000, 1'b1);
      @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      exp_eval = 0; exp_taken = 0;
      check("midreset ready", 32'(ready_o), 32'd1);
      check("midreset done", 32'(done_o), 32'd0);
      check("midreset pc_load", 32'(pc_load_o), 32'd0);
      check("midreset pc_target", 32'(pc_target_o), 32'd0);
      check("midreset err", 32'(err_o), 32'd0);
      check_counters("midreset");
      flags_pending_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      watch_no_done("midreset discarded", 5);

      // Saturation of the 4-bit counters over 20 unconditional jumps
      for (int i = 0; i < 20; i++) begin
         present(COND_JMP, 8'(i), 4'b0000, 1'b0);
         wait_done(lat, ld, tg, er, da, ra);
         exp_eval++; exp_taken++;
         check($sformatf("sat%0d latency", i), 32'(lat), 32'd2);
         check_counters($sformatf("sat%0d", i));
      end
      check("sat final taken", 32'(s_taken_cnt_o), 32'd15);
      check("sat final eval", 32'(s_eval_cnt_o), 32'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
